// File: rtl/muldiv_pkg.sv
// Shared encodings and helpers for the iterative multiply/divide unit.
// The op encoding is fixed because the decode stage drives it directly.
package muldiv_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  // Both signed ops have op[0] clear and both divides have op[1] set.
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Final result formation: restores signs on the magnitude results and
// substitutes the fixed divide-by-zero pattern.
module muldiv_signfix
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]         op,
  input  logic               sign_a,
  input  logic               sign_b,
  input  logic               div0,
  input  logic [2*WIDTH-1:0] prod,
  input  logic [WIDTH-1:0]   quo,
  input  logic [WIDTH-1:0]   rem,
  input  logic [WIDTH-1:0]   a_raw,
  output logic [WIDTH-1:0]   hi_o,
  output logic [WIDTH-1:0]   lo_o
);

  logic               neg_res;
  logic               neg_rem;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    neg_res  = op_is_signed(op) & (sign_a ^ sign_b);
    // Remainder follows the dividend's sign, independent of the divisor.
    neg_rem  = op_is_signed(op) & sign_a;
    prod_fix = neg_res ? -prod : prod;
    quo_fix  = neg_res ? -quo : quo;
    rem_fix  = neg_rem ? -rem : rem;
    hi_o     = prod_fix[2*WIDTH-1:WIDTH];
    lo_o     = prod_fix[WIDTH-1:0];
    if (op_is_div(op)) begin
      if (div0) begin
        hi_o = a_raw;
        lo_o = '1;
      end else begin
        hi_o = rem_fix;
        lo_o = quo_fix;
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers;
// one radix-2 step per cycle, then a sign-fix cycle that commits HI/LO.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for start; HI/LO writable via hi_we/lo_we
// ST_CALC | one shift-add or restoring-divide step per edge, counter down
// ST_FIX  | sign correction, HI/LO commit, done pulse follows
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_req,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] low_q, low_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] a_raw_q, a_raw_d;
  logic [1:0]       op_q, op_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic             div0_q, div0_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             in_sign_a;
  logic             in_sign_b;
  logic [WIDTH-1:0] in_mag_a;
  logic [WIDTH-1:0] in_mag_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_trial;
  logic [WIDTH-1:0] fix_hi;
  logic [WIDTH-1:0] fix_lo;

  always_comb begin
    in_sign_a = op_is_signed(op) & a[WIDTH-1];
    in_sign_b = op_is_signed(op) & b[WIDTH-1];
    in_mag_a  = in_sign_a ? -a : a;
    in_mag_b  = in_sign_b ? -b : b;
  end

  // acc holds the product high half / partial remainder; low holds the
  // multiplier being shifted out / dividend bits being replaced by quotient.
  always_comb begin
    mul_sum   = {1'b0, acc_q} + {1'b0, (low_q[0] ? opb_q : '0)};
    div_shift = {acc_q, low_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, opb_q};
  end

  muldiv_signfix #(
    .WIDTH (WIDTH)
  ) u_signfix (
    .op     (op_q),
    .sign_a (sign_a_q),
    .sign_b (sign_b_q),
    .div0   (div0_q),
    .prod   ({acc_q, low_q}),
    .quo    (low_q),
    .rem    (acc_q),
    .a_raw  (a_raw_q),
    .hi_o   (fix_hi),
    .lo_o   (fix_lo)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    low_d    = low_q;
    opb_d    = opb_q;
    a_raw_d  = a_raw_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    div0_d   = div0_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_CALC;
          cnt_d    = CNT_INIT;
          acc_d    = '0;
          low_d    = in_mag_a;
          opb_d    = in_mag_b;
          a_raw_d  = a;
          op_d     = op;
          sign_a_d = in_sign_a;
          sign_b_d = in_sign_b;
          div0_d   = op_is_div(op) & (b == '0);
        end
      end
      ST_CALC: begin
        cnt_d = cnt_q - CNT_LAST;
        if (op_is_div(op_q)) begin
          if (!div_trial[WIDTH]) begin
            acc_d = div_trial[WIDTH-1:0];
          end else begin
            acc_d = div_shift[WIDTH-1:0];
          end
          low_d = {low_q[WIDTH-2:0], ~div_trial[WIDTH]};
        end else begin
          acc_d = mul_sum[WIDTH:1];
          low_d = {mul_sum[0], low_q[WIDTH-1:1]};
        end
        if (cnt_q == CNT_LAST) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        hi_d    = fix_hi;
        lo_d    = fix_lo;
      end
      default: state_d = ST_IDLE;
    endcase

    // MTHI/MTLO only land while idle; a write on the launch edge is later
    // overwritten by the result commit.
    if (!busy_q) begin
      if (hi_we) hi_d = wdata;
      if (lo_we) lo_d = wdata;
    end

    busy_d = (state_d != ST_IDLE);
    done_d = (state_q == ST_FIX);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      low_q    <= '0;
      opb_q    <= '0;
      a_raw_q  <= '0;
      op_q     <= MD_MULT;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      low_q    <= low_d;
      opb_q    <= opb_d;
      a_raw_q  <= a_raw_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      div0_q   <= div0_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign stall = rd_req & busy_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vectors, randomized
// back-to-back operations against an arithmetic reference, and control cases.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  a, b, wdata;
  logic          hi_we, lo_we, rd_req;
  logic          busy, done, stall;
  logic [W-1:0]  hi, lo;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .hi_we  (hi_we),
    .lo_we  (lo_we),
    .wdata  (wdata),
    .rd_req (rd_req),
    .busy   (busy),
    .done   (done),
    .stall  (stall),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  // Reference result {hi, lo} from plain 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [1:0] mop, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (mop == MD_MULT) begin
      p = sx * sy;
    end else if (mop == MD_MULTU) begin
      p = {32'b0, x} * {32'b0, y};
    end else if (y == 32'b0) begin
      p = {x, 32'hFFFF_FFFF};
    end else if (mop == MD_DIV) begin
      q = sx / sy;
      r = sx % sy;
      p = {32'(r), 32'(q)};
    end else begin
      q = longint'(x) / longint'(y);
      r = longint'(x) % longint'(y);
      p = {32'(r), 32'(q)};
    end
    return p;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 9))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Caller is at a falling edge; returns at the falling edge after busy drops.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int bcnt, output int scnt, output logic early_done);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
    bcnt = 0; scnt = 0; early_done = 1'b0;
    while (busy === 1'b1 && bcnt < 200) begin
      bcnt++;
      if (stall === 1'b1) scnt++;
      if (done !== 1'b0) early_done = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; op = MD_MULT; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0; rd_req = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got=%h want=0", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got=%h want=0", lo); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [1:0]  vop [7] = '{MD_MULT, MD_MULTU, MD_DIV, MD_DIV, MD_DIVU, MD_DIV, MD_DIV};
    logic [31:0] va  [7] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'h8000_0000, 32'd100, 32'd7, 32'hFFFF_FFF9};
    logic [31:0] vb  [7] = '{32'd7, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFE, 32'd0};
    logic [31:0] ehi [7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'd100, 32'd1, 32'hFFFF_FFF9};
    logic [31:0] elo [7] = '{32'hFFFF_FFEB, 32'h0000_0001, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
    int bc, sc;
    logic ed;
    for (int i = 0; i < 7; i++) begin
      run_op(vop[i], va[i], vb[i], bc, sc, ed);
      checks++; if (bc != W + 1) begin errors++; $display("FAIL dir%0d_busy_cycles got=%0d want=%0d", i, bc, W + 1); end
      checks++; if (ed !== 1'b0) begin errors++; $display("FAIL dir%0d_early_done got=1 want=0", i); end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL dir%0d_done got=%b want=1", i, done); end
      checks++; if (hi !== ehi[i]) begin errors++; $display("FAIL dir%0d_hi got=%h want=%h", i, hi, ehi[i]); end
      checks++; if (lo !== elo[i]) begin errors++; $display("FAIL dir%0d_lo got=%h want=%h", i, lo, elo[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  o;
    logic [31:0] x, y;
    logic [63:0] exp_r;
    int bc, sc;
    logic ed;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom);
      x = pick_operand();
      y = pick_operand();
      exp_r = model(o, x, y);
      run_op(o, x, y, bc, sc, ed);
      checks++; if (bc != W + 1 || done !== 1'b1 || ed !== 1'b0) begin
        errors++; $display("FAIL rnd%0d_timing busy_cycles=%0d done=%b early=%b want %0d/1/0", i, bc, done, ed, W + 1);
      end
      checks++; if ({hi, lo} !== exp_r) begin
        errors++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h got=%h_%h want=%h_%h", i, o, x, y, hi, lo, exp_r[63:32], exp_r[31:0]);
      end
    end
  endtask

  task automatic test_stall();
    int bc, sc;
    logic ed;
    rd_req = 1'b1;
    run_op(MD_MULT, $urandom, $urandom, bc, sc, ed);
    checks++; if (sc != W + 1) begin errors++; $display("FAIL stall_cycles got=%0d want=%0d", sc, W + 1); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_done_cycle got=%b want=0", stall); end
    rd_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ignore_busy();
    int bc;
    start = 1'b1; op = MD_MULTU; a = 32'd5; b = 32'd6;
    @(negedge clk);
    start = 1'b0;
    bc = 0;
    while (busy === 1'b1 && bc < 200) begin
      bc++;
      if (bc == 3) begin
        start = 1'b1; op = MD_DIVU; a = 32'd9; b = 32'd3; hi_we = 1'b1; wdata = 32'h1234;
      end else begin
        start = 1'b0; hi_we = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0; hi_we = 1'b0;
    checks++; if (bc != W + 1) begin errors++; $display("FAIL ign_busy_cycles got=%0d want=%0d", bc, W + 1); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL ign_hi got=%h want=0", hi); end
    checks++; if (lo !== 32'd30) begin errors++; $display("FAIL ign_lo got=%h want=1e", lo); end
    hi_we = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    hi_we = 1'b0;
    checks++; if (hi !== 32'h1234) begin errors++; $display("FAIL idle_mthi got=%h want=1234", hi); end
    checks++; if (lo !== 32'd30) begin errors++; $display("FAIL idle_mthi_lo got=%h want=1e", lo); end
  endtask

  task automatic test_we_with_start();
    int bc, sc;
    logic ed;
    start = 1'b1; op = MD_MULTU; a = 32'd3; b = 32'd4;
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hABCD;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    checks++; if (hi !== 32'hABCD || lo !== 32'hABCD) begin
      errors++; $display("FAIL we_on_start got=%h_%h want=0000abcd_0000abcd", hi, lo);
    end
    bc = 0;
    while (busy === 1'b1 && bc < 200) begin bc++; @(negedge clk); end
    checks++; if (hi !== 32'h0 || lo !== 32'd12 || done !== 1'b1) begin
      errors++; $display("FAIL we_overwritten got=%h_%h done=%b want=00000000_0000000c done=1", hi, lo, done);
    end
    run_op(MD_DIVU, 32'd12, 32'd5, bc, sc, ed);
    checks++; if (hi !== 32'd2 || lo !== 32'd2) begin errors++; $display("FAIL after_we got=%h_%h want=2_2", hi, lo); end
  endtask

  task automatic test_midop_reset();
    int bc, sc;
    logic ed;
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h55;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    start = 1'b1; op = MD_DIVU; a = 32'd1000; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midrst_ctrl busy=%b done=%b want 0/0", busy, done); end
    checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL midrst_hilo got=%h_%h want=0_0", hi, lo); end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (done !== 1'b0 || hi !== 32'h0) begin errors++; $display("FAIL midrst_no_partial done=%b hi=%h want 0/0", done, hi); end
    run_op(MD_DIVU, 32'd1000, 32'd7, bc, sc, ed);
    checks++; if (bc != W + 1 || done !== 1'b1) begin errors++; $display("FAIL postrst_timing cycles=%0d done=%b want %0d/1", bc, done, W + 1); end
    checks++; if (lo !== 32'd142 || hi !== 32'd6) begin errors++; $display("FAIL postrst_result got=%h_%h want=6_8e", hi, lo); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_ignore_busy();
    test_we_with_start();
    test_midop_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
